// File: rtl/rv_fetch_queue_if.sv
// Fetch-side bus bundle for rv_fetch_queue: instruction memory port, redirect input
// and the decode-facing queue head. master = fetch queue, slave = core/memory side.
interface rv_fetch_queue_if #(
  parameter int XLEN = 32
);
  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_inst;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      fifo_count;

  modport master (
    output mem_req, mem_addr, out_valid, out_inst, out_pc, fifo_count,
    input  mem_rdata, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  mem_req, mem_addr, out_valid, out_inst, out_pc, fifo_count,
    output mem_rdata, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/rv_fetch_queue.sv
// RV32 instruction-fetch front end: credit-based issue, PC-tagged fetch queue, redirect flush.
// Optional macro FETCH_BSWAP_EN byte-swaps each returned word before it is queued.
module rv_fetch_queue_chk #(
  parameter int FIFO_DEPTH = 4
) (
  input logic       clk,
  input logic       rst,
  input logic       push,
  input logic       pop,
  input logic       flush,
  input logic [4:0] count
);
  localparam logic [4:0] DEPTH_C = 5'(FIFO_DEPTH);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && !pop && !flush && (count == DEPTH_C)));

  a_count_range: assert property (@(posedge clk) disable iff (!rst)
    (count <= DEPTH_C));
endmodule

module rv_fetch_queue #(
  parameter int          XLEN       = 32,
  parameter logic [31:0] RESET_PC   = 32'h4000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input logic             clk,
  input logic             rst,
  rv_fetch_queue_if.master bus
);
  localparam int             PW       = $clog2(FIFO_DEPTH);
  localparam logic [PW-1:0]  PTR_ONE  = PW'(1'b1);
  localparam logic [5:0]     DEPTH_CR = 6'(FIFO_DEPTH);
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  logic [XLEN-1:0] fetch_pc_r, rsp_pc_r;
  logic            inflight_r;
  logic [4:0]      count_r, count_n;
  logic            out_valid_r, out_valid_n;
  logic [XLEN-1:0] out_inst_r, out_inst_n, out_pc_r, out_pc_n;
  logic [PW-1:0]   rd_ptr_r, rd_ptr_n, wr_ptr_r, wr_ptr_n;
  logic [XLEN-1:0] body_inst_r [FIFO_DEPTH];
  logic [XLEN-1:0] body_pc_r   [FIFO_DEPTH];

  logic            mem_req_s, kill_s, push_s, pop_s, body_we_s;
  logic [XLEN-1:0] mem_addr_s, push_inst_s;
  logic [5:0]      credit_s;
  logic [4:0]      body_cnt_s;

`ifdef FETCH_BSWAP_EN
  assign push_inst_s = bswap32(bus.mem_rdata);
`else
  assign push_inst_s = bus.mem_rdata;
`endif

  // A read landing in a redirect cycle belongs to the old path and is dropped.
  assign kill_s     = inflight_r & bus.redirect_valid;
  assign push_s     = inflight_r & ~kill_s;
  assign pop_s      = out_valid_r & bus.out_ready;
  assign body_cnt_s = count_r - {4'd0, out_valid_r};
  assign credit_s   = {1'b0, count_r} + {5'd0, inflight_r} - {5'd0, pop_s};

  // Request issue: reserve a queue slot for every read before it is sent.
  always_comb begin
    mem_req_s  = 1'b0;
    mem_addr_s = fetch_pc_r;
    if (bus.redirect_valid) begin
      mem_addr_s = {bus.redirect_pc[XLEN-1:2], 2'b00};
    end else begin
      mem_addr_s = fetch_pc_r;
    end
    if (rst && (bus.redirect_valid || (credit_s < DEPTH_CR))) begin
      mem_req_s = 1'b1;
    end else begin
      mem_req_s = 1'b0;
    end
  end

  // Queue next state: head register is refilled from the body or directly from memory.
  always_comb begin
    count_n     = count_r;
    out_valid_n = out_valid_r;
    out_inst_n  = out_inst_r;
    out_pc_n    = out_pc_r;
    rd_ptr_n    = rd_ptr_r;
    wr_ptr_n    = wr_ptr_r;
    body_we_s   = 1'b0;
    if (bus.redirect_valid) begin
      count_n     = 5'd0;
      out_valid_n = 1'b0;
      rd_ptr_n    = '0;
      wr_ptr_n    = '0;
    end else begin
      if (push_s && !pop_s) begin
        count_n = count_r + 5'd1;
      end else if (!push_s && pop_s) begin
        count_n = count_r - 5'd1;
      end else begin
        count_n = count_r;
      end
      if (pop_s) begin
        if (body_cnt_s != 5'd0) begin
          out_inst_n  = body_inst_r[rd_ptr_r];
          out_pc_n    = body_pc_r[rd_ptr_r];
          out_valid_n = 1'b1;
          rd_ptr_n    = rd_ptr_r + PTR_ONE;
          if (push_s) begin
            body_we_s = 1'b1;
            wr_ptr_n  = wr_ptr_r + PTR_ONE;
          end else begin
            body_we_s = 1'b0;
          end
        end else if (push_s) begin
          out_inst_n  = push_inst_s;
          out_pc_n    = rsp_pc_r;
          out_valid_n = 1'b1;
        end else begin
          out_valid_n = 1'b0;
        end
      end else if (push_s) begin
        if (out_valid_r) begin
          body_we_s = 1'b1;
          wr_ptr_n  = wr_ptr_r + PTR_ONE;
        end else begin
          out_inst_n  = push_inst_s;
          out_pc_n    = rsp_pc_r;
          out_valid_n = 1'b1;
        end
      end else begin
        out_valid_n = out_valid_r;
      end
    end
  end

  // Control and head registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_r  <= RESET_PC;
      rsp_pc_r    <= '0;
      inflight_r  <= 1'b0;
      count_r     <= 5'd0;
      out_valid_r <= 1'b0;
      out_inst_r  <= '0;
      out_pc_r    <= '0;
      rd_ptr_r    <= '0;
      wr_ptr_r    <= '0;
    end else begin
      if (mem_req_s) begin
        fetch_pc_r <= mem_addr_s + PC_STEP;
      end else begin
        fetch_pc_r <= fetch_pc_r;
      end
      inflight_r  <= mem_req_s;
      rsp_pc_r    <= mem_addr_s;
      count_r     <= count_n;
      out_valid_r <= out_valid_n;
      out_inst_r  <= out_inst_n;
      out_pc_r    <= out_pc_n;
      rd_ptr_r    <= rd_ptr_n;
      wr_ptr_r    <= wr_ptr_n;
    end
  end

  // Body storage holds data only; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (body_we_s) begin
      body_inst_r[wr_ptr_r] <= push_inst_s;
      body_pc_r[wr_ptr_r]   <= rsp_pc_r;
    end
  end

  assign bus.mem_req    = mem_req_s;
  assign bus.mem_addr   = mem_addr_s;
  assign bus.out_valid  = out_valid_r;
  assign bus.out_inst   = out_inst_r;
  assign bus.out_pc     = out_pc_r;
  assign bus.fifo_count = count_r;

  rv_fetch_queue_chk #(.FIFO_DEPTH(FIFO_DEPTH)) u_chk (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .flush (bus.redirect_valid),
    .count (count_r)
  );
endmodule

// File: tb/tb_rv_fetch_queue.sv
// Directed bench for rv_fetch_queue (FIFO_DEPTH=4); memory returns word=address,
// or a fixed 1234_5678 pattern when data_mode=1.
module tb_rv_fetch_queue;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic data_mode = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  rv_fetch_queue_if #(.XLEN(32)) bus ();

  rv_fetch_queue #(.XLEN(32), .RESET_PC(32'h4000_0000), .FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // synchronous-read memory: data valid one cycle after the request
  always @(posedge clk) begin
    if (bus.mem_req) bus.mem_rdata <= data_mode ? 32'h1234_5678 : bus.mem_addr;
  end

  function automatic logic [31:0] exp_inst(input logic [31:0] addr);
    logic [31:0] w;
    w = data_mode ? 32'h1234_5678 : addr;
`ifdef FETCH_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic cyc(input logic rdy, input logic rv, input logic [31:0] rpc);
    @(negedge clk);
    bus.out_ready      = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = rdy;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_count", {27'd0, bus.fifo_count}, 32'd0);
  endtask

  task automatic release_rst(input logic rdy);
    @(negedge clk);
    rst = 1'b1;
    bus.out_ready = rdy;
    #1;
  endtask

  initial begin
    bus.mem_rdata = 32'h0;
    bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;

    // 1: streaming after reset
    do_reset(1'b1);
    check("rst_out_inst", bus.out_inst, 32'h0);
    check("rst_out_pc", bus.out_pc, 32'h0);
    release_rst(1'b1);
    for (int k = 0; k < 7; k++) begin
      if (k > 0) cyc(1'b1, 1'b0, 32'h0);
      check("t1_mem_req", {31'd0, bus.mem_req}, 32'd1);
      check("t1_mem_addr", bus.mem_addr, 32'h4000_0000 + 32'(4 * k));
      if (k < 2) begin
        check("t1_out_valid_lat", {31'd0, bus.out_valid}, 32'd0);
      end else begin
        check("t1_out_valid", {31'd0, bus.out_valid}, 32'd1);
        check("t1_out_pc", bus.out_pc, 32'h4000_0000 + 32'(4 * (k - 2)));
        check("t1_out_inst", bus.out_inst, exp_inst(32'h4000_0000 + 32'(4 * (k - 2))));
      end
    end

    // 2: decode stalled, queue fills to 4, then drains in order
    do_reset(1'b0);
    release_rst(1'b0);
    for (int k = 1; k < 6; k++) begin
      cyc(1'b0, 1'b0, 32'h0);
      check("t2_count", {27'd0, bus.fifo_count}, 32'(k - 1));
      if (k >= 4) check("t2_mem_req_stop", {31'd0, bus.mem_req}, 32'd0);
    end
    for (int k = 0; k < 5; k++) begin
      cyc(1'b1, 1'b0, 32'h0);
      check("t2_drain_valid", {31'd0, bus.out_valid}, 32'd1);
      check("t2_drain_pc", bus.out_pc, 32'h4000_0000 + 32'(4 * k));
    end

    // 3: redirect with three queued and one read in flight
    do_reset(1'b0);
    release_rst(1'b0);
    for (int k = 1; k < 4; k++) cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 32'h0000_1002);
    check("t3_pre_count", {27'd0, bus.fifo_count}, 32'd3);
    check("t3_redir_req", {31'd0, bus.mem_req}, 32'd1);
    check("t3_redir_addr", bus.mem_addr, 32'h0000_1000);
    cyc(1'b0, 1'b0, 32'h0);
    check("t3_flush_count", {27'd0, bus.fifo_count}, 32'd0);
    check("t3_flush_valid", {31'd0, bus.out_valid}, 32'd0);
    check("t3_next_addr", bus.mem_addr, 32'h0000_1004);
    cyc(1'b0, 1'b0, 32'h0);
    check("t3_tgt_valid", {31'd0, bus.out_valid}, 32'd1);
    check("t3_tgt_pc", bus.out_pc, 32'h0000_1000);
    check("t3_tgt_inst", bus.out_inst, exp_inst(32'h0000_1000));
    check("t3_tgt_count", {27'd0, bus.fifo_count}, 32'd1);

    // 4: back-to-back redirects, last one wins
    do_reset(1'b1);
    release_rst(1'b1);
    for (int k = 1; k < 3; k++) cyc(1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 32'h0000_2000);
    check("t4_a_addr", bus.mem_addr, 32'h0000_2000);
    cyc(1'b1, 1'b1, 32'h0000_3000);
    check("t4_b_addr", bus.mem_addr, 32'h0000_3000);
    check("t4_b_valid", {31'd0, bus.out_valid}, 32'd0);
    cyc(1'b1, 1'b0, 32'h0);
    check("t4_gap_valid", {31'd0, bus.out_valid}, 32'd0);
    cyc(1'b1, 1'b0, 32'h0);
    check("t4_b_out_valid", {31'd0, bus.out_valid}, 32'd1);
    check("t4_b_out_pc", bus.out_pc, 32'h0000_3000);
    cyc(1'b1, 1'b0, 32'h0);
    check("t4_b_out_pc2", bus.out_pc, 32'h0000_3004);

    // 5: redirect and pop in the same cycle with 3 entries
    do_reset(1'b0);
    release_rst(1'b0);
    for (int k = 1; k < 4; k++) cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 32'h0000_5000);
    check("t5_pop_valid", {31'd0, bus.out_valid}, 32'd1);
    check("t5_pop_pc", bus.out_pc, 32'h4000_0000);
    cyc(1'b1, 1'b0, 32'h0);
    check("t5_after_valid", {31'd0, bus.out_valid}, 32'd0);
    check("t5_after_count", {27'd0, bus.fifo_count}, 32'd0);
    cyc(1'b1, 1'b0, 32'h0);
    check("t5_tgt_pc", bus.out_pc, 32'h0000_5000);

    // 6: fixed data pattern (byte order) and address wrap at the top of memory
    do_reset(1'b1);
    data_mode = 1'b1;
    release_rst(1'b1);
    cyc(1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0);
`ifdef FETCH_BSWAP_EN
    check("t6_inst_swap", bus.out_inst, 32'h7856_3412);
`else
    check("t6_inst_plain", bus.out_inst, 32'h1234_5678);
`endif
    cyc(1'b1, 1'b1, 32'hFFFF_FFFE);
    check("t6_wrap_addr", bus.mem_addr, 32'hFFFF_FFFC);
    cyc(1'b1, 1'b0, 32'h0);
    check("t6_wrap_next", bus.mem_addr, 32'h0000_0000);
    cyc(1'b1, 1'b0, 32'h0);
    check("t6_wrap_pc", bus.out_pc, 32'hFFFF_FFFC);
    cyc(1'b1, 1'b0, 32'h0);
    check("t6_wrap_pc2", bus.out_pc, 32'h0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
